// File: rtl/mem_wb_stage_if.sv
// Bundle between execute, the mem/wb stage, data memory and the register-file write port.
// The stage uses the slave modport; the surrounding pipeline/testbench uses master.
interface mem_wb_stage_if;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_alu_result;
  logic [31:0] ex_store_data;
  logic [31:0] ex_link_data;
  logic [4:0]  ex_rd;
  logic        ex_mem_rd;
  logic        ex_memwr;
  logic        ex_wb_en;
  logic [1:0]  ex_wb_data_sel;
  logic        ex_wb_reg_sel;
  logic        ex_sp_we;
  logic [31:0] ex_sp_next;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        sp_we;
  logic [31:0] sp_wdata;
  logic        busy;
  logic        err;

  modport slave (
    input  ex_valid, ex_alu_result, ex_store_data, ex_link_data, ex_rd, ex_mem_rd,
           ex_memwr, ex_wb_en, ex_wb_data_sel, ex_wb_reg_sel, ex_sp_we, ex_sp_next,
           mem_rdata, mem_ack,
    output ex_ready, mem_req, mem_we, mem_addr, mem_wdata,
           rf_we, rf_waddr, rf_wdata, sp_we, sp_wdata, busy, err
  );

  modport master (
    output ex_valid, ex_alu_result, ex_store_data, ex_link_data, ex_rd, ex_mem_rd,
           ex_memwr, ex_wb_en, ex_wb_data_sel, ex_wb_reg_sel, ex_sp_we, ex_sp_next,
           mem_rdata, mem_ack,
    input  ex_ready, mem_req, mem_we, mem_addr, mem_wdata,
           rf_we, rf_waddr, rf_wdata, sp_we, sp_wdata, busy, err
  );
endinterface

// File: rtl/mem_wb_stage.sv
// Pipeline back end: captures the execute bundle, performs the optional data access, drives RF/SP writes.
// Define MEM_TIMEOUT_EN to bound the wait on mem_ack (abort plus sticky err after MEM_TIMEOUT cycles).
module mem_wb_stage #(
  parameter logic [4:0] LR_IDX = 5'd30
`ifdef MEM_TIMEOUT_EN
  , parameter int MEM_TIMEOUT = 16
`endif
) (
  input logic           clk,
  input logic           rst_n,
  mem_wb_stage_if.slave bus
);

  // state | meaning
  // IDLE  | no instruction in flight, ready for a bundle
  // MEM   | data access outstanding, waiting for mem_ack
  // WB    | single writeback cycle, may accept the next bundle
  typedef enum logic [1:0] {IDLE, MEM, WB} state_t;

  state_t      state, state_nxt;
  logic        accept, go_mem, in_mem, in_wb, timeout;
  logic [31:0] alu_q, store_q, link_q, sp_next_q, rdata_q, wb_data;
  logic [4:0]  rd_q, waddr;
  logic [1:0]  sel_q;
  logic        memwr_q, wb_en_q, reg_sel_q, sp_we_q, abort_q;

  assign in_mem = (state == MEM);
  assign in_wb  = (state == WB);
  assign accept = bus.ex_valid && bus.ex_ready;
  assign go_mem = bus.ex_mem_rd || bus.ex_memwr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = go_mem ? MEM : WB;
      MEM:     if (bus.mem_ack || timeout) state_nxt = WB;
      WB:      state_nxt = accept ? (go_mem ? MEM : WB) : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_q     <= '0;
      store_q   <= '0;
      link_q    <= '0;
      rd_q      <= '0;
      memwr_q   <= 1'b0;
      wb_en_q   <= 1'b0;
      sel_q     <= '0;
      reg_sel_q <= 1'b0;
      sp_we_q   <= 1'b0;
      sp_next_q <= '0;
      rdata_q   <= '0;
      abort_q   <= 1'b0;
    end else if (accept) begin
      alu_q     <= bus.ex_alu_result;
      store_q   <= bus.ex_store_data;
      link_q    <= bus.ex_link_data;
      rd_q      <= bus.ex_rd;
      memwr_q   <= bus.ex_memwr;
      wb_en_q   <= bus.ex_wb_en;
      sel_q     <= bus.ex_wb_data_sel;
      reg_sel_q <= bus.ex_wb_reg_sel;
      sp_we_q   <= bus.ex_sp_we;
      sp_next_q <= bus.ex_sp_next;
      rdata_q   <= '0;
      abort_q   <= 1'b0;
    end else if (in_mem && bus.mem_ack) begin
      // a combined read+write is treated as a write, so it returns no data
      rdata_q   <= memwr_q ? 32'h0 : bus.mem_rdata;
    end else if (timeout) begin
      abort_q   <= 1'b1;
    end
  end

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q;
  logic             err_q;

  // an ack in the final cycle takes priority over the abort
  assign timeout = in_mem && !bus.mem_ack && (cnt_q == CNT_W'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= in_mem ? cnt_q + 1'b1 : '0;
      if (timeout) err_q <= 1'b1;
    end
  end

  assign bus.err = err_q;
`else
  assign timeout = 1'b0;
  assign bus.err = 1'b0;
`endif

  always_comb begin
    wb_data = alu_q;
    case (sel_q)
      2'b01:   wb_data = rdata_q;
      2'b10:   wb_data = link_q;
      default: wb_data = alu_q;
    endcase
  end

  assign waddr = reg_sel_q ? LR_IDX : rd_q;

  assign bus.ex_ready  = !in_mem;
  assign bus.busy      = in_mem;
  assign bus.mem_req   = in_mem;
  assign bus.mem_we    = in_mem && memwr_q;
  assign bus.mem_addr  = in_mem ? alu_q : 32'h0;
  assign bus.mem_wdata = in_mem ? store_q : 32'h0;

  assign bus.rf_we     = in_wb && wb_en_q && (waddr != 5'd0) && !abort_q;
  assign bus.rf_waddr  = in_wb ? waddr : 5'd0;
  assign bus.rf_wdata  = in_wb ? wb_data : 32'h0;
  assign bus.sp_we     = in_wb && sp_we_q && !abort_q;
  assign bus.sp_wdata  = in_wb ? sp_next_q : 32'h0;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: vector table, directed multi-cycle sequences, and a
// randomized instruction stream checked against a transaction-level model with a memory array.
module tb_mem_wb_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_wb_stage_if bus();
  mem_wb_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] link;
    logic [4:0]  rd;
    logic        wb_en;
    logic [1:0]  sel;
    logic        reg_sel;
    logic        sp_we;
    logic [31:0] sp_next;
    logic        e_we;
    logic [4:0]  e_waddr;
    logic [31:0] e_wdata;
    logic        e_sp_we;
    logic [31:0] e_sp;
  } vec_t;

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        sp_we;
    logic [31:0] sp;
  } wb_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mtx_t;

  localparam int NV = 8;
  vec_t vecs[NV];

  wb_t         exp_q[$];
  mtx_t        mexp_q[$];
  logic [31:0] mem_dev[16];
  logic [31:0] mem_ref[16];
  bit          run;
  int          cnt;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk5(input string name, input logic [4:0] act, input logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_ex();
    bus.ex_valid       = 1'b0;
    bus.ex_alu_result  = '0;
    bus.ex_store_data  = '0;
    bus.ex_link_data   = '0;
    bus.ex_rd          = '0;
    bus.ex_mem_rd      = 1'b0;
    bus.ex_memwr       = 1'b0;
    bus.ex_wb_en       = 1'b0;
    bus.ex_wb_data_sel = '0;
    bus.ex_wb_reg_sel  = 1'b0;
    bus.ex_sp_we       = 1'b0;
    bus.ex_sp_next     = '0;
  endtask

  task automatic drive_ex(input logic [31:0] alu, input logic [31:0] store, input logic [31:0] link,
                          input logic [4:0] rd, input logic mrd, input logic mwr, input logic wben,
                          input logic [1:0] sel, input logic regsel, input logic spwe,
                          input logic [31:0] spnext);
    bus.ex_valid       = 1'b1;
    bus.ex_alu_result  = alu;
    bus.ex_store_data  = store;
    bus.ex_link_data   = link;
    bus.ex_rd          = rd;
    bus.ex_mem_rd      = mrd;
    bus.ex_memwr       = mwr;
    bus.ex_wb_en       = wben;
    bus.ex_wb_data_sel = sel;
    bus.ex_wb_reg_sel  = regsel;
    bus.ex_sp_we       = spwe;
    bus.ex_sp_next     = spnext;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    //                 alu           link          rd     wb   sel    rsel  spwe  sp_next       we    waddr   wdata         spwe  sp
    vecs[0] = '{32'h0000_1234, 32'h0,        5'd5,  1'b1, 2'b00, 1'b0, 1'b0, 32'h0,        1'b1, 5'd5,  32'h0000_1234, 1'b0, 32'h0};
    vecs[1] = '{32'h0000_0099, 32'h0000_0041, 5'd7,  1'b1, 2'b10, 1'b1, 1'b0, 32'h0,        1'b1, 5'd30, 32'h0000_0041, 1'b0, 32'h0};
    vecs[2] = '{32'h0000_0777, 32'h0,        5'd0,  1'b1, 2'b00, 1'b0, 1'b0, 32'h0,        1'b0, 5'd0,  32'h0,         1'b0, 32'h0};
    vecs[3] = '{32'h0000_CAFE, 32'h0,        5'd7,  1'b1, 2'b11, 1'b0, 1'b0, 32'h0,        1'b1, 5'd7,  32'h0000_CAFE, 1'b0, 32'h0};
    vecs[4] = '{32'h0000_0005, 32'h0,        5'd3,  1'b0, 2'b00, 1'b0, 1'b1, 32'h0000_2FFF, 1'b0, 5'd0,  32'h0,         1'b1, 32'h0000_2FFF};
    vecs[5] = '{32'hFFFF_FFFF, 32'h0,        5'd31, 1'b1, 2'b00, 1'b0, 1'b1, 32'h0000_0100, 1'b1, 5'd31, 32'hFFFF_FFFF, 1'b1, 32'h0000_0100};
    vecs[6] = '{32'h0000_0008, 32'h0000_1000, 5'd0,  1'b1, 2'b10, 1'b1, 1'b0, 32'h0,        1'b1, 5'd30, 32'h0000_1000, 1'b0, 32'h0};
    vecs[7] = '{32'h0000_0ABC, 32'h0000_0005, 5'd12, 1'b1, 2'b10, 1'b0, 1'b0, 32'h0,        1'b1, 5'd12, 32'h0000_0005, 1'b0, 32'h0};

    clear_ex();
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk1("reset ex_ready", bus.ex_ready, 1'b1);
    chk1("reset rf_we", bus.rf_we, 1'b0);
    chk1("reset mem_req", bus.mem_req, 1'b0);
    chk1("reset sp_we", bus.sp_we, 1'b0);
    chk1("reset busy", bus.busy, 1'b0);
    chk1("reset err", bus.err, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // back-to-back non-memory ops; a stray ack outside MEM must be ignored
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h5A5A_5A5A;
    for (int i = 0; i < NV; i++) begin
      drive_ex(vecs[i].alu, 32'h0, vecs[i].link, vecs[i].rd, 1'b0, 1'b0, vecs[i].wb_en,
               vecs[i].sel, vecs[i].reg_sel, vecs[i].sp_we, vecs[i].sp_next);
      @(negedge clk);
      chk1($sformatf("vec%0d rf_we", i), bus.rf_we, vecs[i].e_we);
      if (vecs[i].e_we) begin
        chk5($sformatf("vec%0d rf_waddr", i), bus.rf_waddr, vecs[i].e_waddr);
        chk32($sformatf("vec%0d rf_wdata", i), bus.rf_wdata, vecs[i].e_wdata);
      end
      chk1($sformatf("vec%0d sp_we", i), bus.sp_we, vecs[i].e_sp_we);
      if (vecs[i].e_sp_we) chk32($sformatf("vec%0d sp_wdata", i), bus.sp_wdata, vecs[i].e_sp);
      chk1($sformatf("vec%0d ex_ready", i), bus.ex_ready, 1'b1);
      chk1($sformatf("vec%0d mem_req", i), bus.mem_req, 1'b0);
    end
    clear_ex();
    bus.mem_ack = 1'b0;
    @(negedge clk);
    chk1("pulse end rf_we", bus.rf_we, 1'b0);
    chk1("pulse end sp_we", bus.sp_we, 1'b0);

    // load with ack in the fourth MEM cycle
    drive_ex(32'h0000_3000, 32'h0, 32'h0, 5'd4, 1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    clear_ex();
    for (int k = 1; k <= 4; k++) begin
      chk1($sformatf("load c%0d mem_req", k), bus.mem_req, 1'b1);
      chk1($sformatf("load c%0d mem_we", k), bus.mem_we, 1'b0);
      chk32($sformatf("load c%0d mem_addr", k), bus.mem_addr, 32'h0000_3000);
      chk1($sformatf("load c%0d ex_ready", k), bus.ex_ready, 1'b0);
      chk1($sformatf("load c%0d busy", k), bus.busy, 1'b1);
      chk1($sformatf("load c%0d rf_we", k), bus.rf_we, 1'b0);
      if (k == 4) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hDEAD_BEEF;
      end
      @(negedge clk);
    end
    bus.mem_ack = 1'b0;
    chk1("load wb mem_req", bus.mem_req, 1'b0);
    chk1("load wb rf_we", bus.rf_we, 1'b1);
    chk5("load wb rf_waddr", bus.rf_waddr, 5'd4);
    chk32("load wb rf_wdata", bus.rf_wdata, 32'hDEAD_BEEF);
    chk1("load wb ex_ready", bus.ex_ready, 1'b1);
    @(negedge clk);
    chk1("load after rf_we", bus.rf_we, 1'b0);

    // push, then a read+write access accepted in the push's WB cycle
    drive_ex(32'h0000_2FFF, 32'h0000_0055, 32'h0, 5'd0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 32'h0000_2FFF);
    @(negedge clk);
    clear_ex();
    chk1("push mem_req", bus.mem_req, 1'b1);
    chk1("push mem_we", bus.mem_we, 1'b1);
    chk32("push mem_wdata", bus.mem_wdata, 32'h0000_0055);
    chk32("push mem_addr", bus.mem_addr, 32'h0000_2FFF);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h1111_2222;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    chk1("push sp_we", bus.sp_we, 1'b1);
    chk32("push sp_wdata", bus.sp_wdata, 32'h0000_2FFF);
    chk1("push rf_we", bus.rf_we, 1'b0);
    chk1("push wb mem_req", bus.mem_req, 1'b0);
    drive_ex(32'h0000_0010, 32'h0000_0077, 32'h0, 5'd9, 1'b1, 1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    clear_ex();
    chk1("rdwr busy", bus.busy, 1'b1);
    chk1("rdwr mem_we", bus.mem_we, 1'b1);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hFFFF_1111;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    chk1("rdwr rf_we", bus.rf_we, 1'b1);
    chk32("rdwr rf_wdata", bus.rf_wdata, 32'h0);
    @(negedge clk);

    // asynchronous reset while a load is outstanding
    drive_ex(32'h0000_0020, 32'h0, 32'h0, 5'd8, 1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 1'b1, 32'h0000_0333);
    @(negedge clk);
    clear_ex();
    chk1("rstmid mem_req before", bus.mem_req, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk1("rstmid mem_req", bus.mem_req, 1'b0);
    chk1("rstmid busy", bus.busy, 1'b0);
    chk1("rstmid ex_ready", bus.ex_ready, 1'b1);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h9999_9999;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk1($sformatf("rstmid post%0d rf_we", k), bus.rf_we, 1'b0);
      chk1($sformatf("rstmid post%0d sp_we", k), bus.sp_we, 1'b0);
      chk1($sformatf("rstmid post%0d mem_req", k), bus.mem_req, 1'b0);
    end

`ifdef MEM_TIMEOUT_EN
    drive_ex(32'h0000_0080, 32'h0, 32'h0, 5'd6, 1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 1'b1, 32'h0000_0044);
    @(negedge clk);
    clear_ex();
    cnt = 0;
    while (bus.mem_req && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
    chk32("timeout req cycles", cnt, 32'd16);
    chk1("timeout err", bus.err, 1'b1);
    chk1("timeout rf_we", bus.rf_we, 1'b0);
    chk1("timeout sp_we", bus.sp_we, 1'b0);
    @(negedge clk);
    drive_ex(32'h0000_00AA, 32'h0, 32'h0, 5'd2, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    clear_ex();
    chk1("timeout next rf_we", bus.rf_we, 1'b1);
    chk1("timeout err sticky", bus.err, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk1("timeout err cleared", bus.err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    drive_ex(32'h0000_0084, 32'h0, 32'h0, 5'd6, 1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    clear_ex();
    repeat (15) @(negedge clk);
    chk1("lastcycle mem_req", bus.mem_req, 1'b1);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h0BAD_F00D;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    chk1("lastcycle ack rf_we", bus.rf_we, 1'b1);
    chk32("lastcycle ack rf_wdata", bus.rf_wdata, 32'h0BAD_F00D);
    chk1("lastcycle ack err", bus.err, 1'b0);
    @(negedge clk);
`else
    drive_ex(32'h0000_0040, 32'h0, 32'h0, 5'd6, 1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    clear_ex();
    repeat (40) @(negedge clk);
    chk1("longwait mem_req", bus.mem_req, 1'b1);
    chk1("longwait busy", bus.busy, 1'b1);
    chk1("longwait err", bus.err, 1'b0);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h1234_5678;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    chk1("longwait rf_we", bus.rf_we, 1'b1);
    chk32("longwait rf_wdata", bus.rf_wdata, 32'h1234_5678);
    @(negedge clk);
`endif

    // randomized instruction stream against a transaction-level model
    for (int i = 0; i < 16; i++) begin
      mem_dev[i] = 32'h1000_0000 + 32'(i) * 32'h0101_0101;
      mem_ref[i] = mem_dev[i];
    end
    run = 1'b1;
    fork
      begin : driver
        for (int n = 0; n < 300; n++) begin
          int          kind, w;
          logic [31:0] alu, store, link, spn, mdata, data;
          logic [4:0]  rd, wa;
          logic [1:0]  sel;
          logic        mrd, mwr, wben, rsel, spwe, we;
          wb_t         e;
          repeat ($urandom_range(0, 2)) @(negedge clk);
          kind  = int'($urandom_range(0, 3));
          alu   = $urandom;
          store = $urandom;
          link  = $urandom;
          spn   = $urandom;
          rd    = 5'($urandom_range(0, 31));
          if ($urandom_range(0, 7) == 0) rd = 5'd0;
          wben  = ($urandom_range(0, 4) != 0);
          rsel  = ($urandom_range(0, 5) == 0);
          spwe  = ($urandom_range(0, 3) == 0);
          mrd   = (kind == 1) || (kind == 3 && $urandom_range(0, 1) == 1);
          mwr   = (kind == 2) || (kind == 3 && !mrd);
          if (kind == 3 && $urandom_range(0, 3) == 0) begin
            mrd = 1'b1;
            mwr = 1'b1;
          end
          sel   = 2'($urandom_range(0, 3));
          if (!(mrd || mwr) && sel == 2'b01) sel = 2'b00;
          mdata = 32'h0;
          if (mrd || mwr) begin
            mexp_q.push_back('{mwr, alu, store});
            if (mwr) mem_ref[alu[3:0]] = store;
            else     mdata = mem_ref[alu[3:0]];
          end
          wa   = rsel ? 5'd30 : rd;
          data = (sel == 2'b01) ? mdata : (sel == 2'b10) ? link : alu;
          we   = wben && (wa != 5'd0);
          if (we || spwe) begin
            e.we    = we;
            e.waddr = we ? wa : 5'd0;
            e.wdata = we ? data : 32'h0;
            e.sp_we = spwe;
            e.sp    = spwe ? spn : 32'h0;
            exp_q.push_back(e);
          end
          drive_ex(alu, store, link, rd, mrd, mwr, wben, sel, rsel, spwe, spn);
          w = 0;
          while (!bus.ex_ready && w < 50) begin
            @(negedge clk);
            w++;
          end
          if (w >= 50) begin
            errors++;
            checks++;
            $display("FAIL rand accept: ex_ready stayed %b for %0d cycles, required 1", bus.ex_ready, w);
          end
          @(negedge clk);
          bus.ex_valid = 1'b0;
        end
        repeat (12) @(negedge clk);
        run = 1'b0;
      end
      begin : responder
        bit          active = 1'b0;
        int          remain = 0;
        logic        h_we;
        logic [31:0] h_addr, h_wdata;
        mtx_t        m;
        while (run) begin
          @(negedge clk);
          if (bus.mem_req) begin
            if (!active) begin
              active  = 1'b1;
              remain  = int'($urandom_range(0, 3));
              h_we    = bus.mem_we;
              h_addr  = bus.mem_addr;
              h_wdata = bus.mem_wdata;
              checks++;
              if (mexp_q.size() == 0) begin
                errors++;
                $display("FAIL rand memreq: unexpected request we=%b addr=%h, required none", h_we, h_addr);
              end else begin
                m = mexp_q.pop_front();
                if ({h_we, h_addr, h_wdata} !== {m.we, m.addr, m.wdata}) begin
                  errors++;
                  $display("FAIL rand memreq: got we=%b addr=%h wdata=%h expected we=%b addr=%h wdata=%h",
                           h_we, h_addr, h_wdata, m.we, m.addr, m.wdata);
                end
              end
            end else if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {h_we, h_addr, h_wdata}) begin
              errors++;
              checks++;
              $display("FAIL rand memhold: got we=%b addr=%h wdata=%h expected we=%b addr=%h wdata=%h",
                       bus.mem_we, bus.mem_addr, bus.mem_wdata, h_we, h_addr, h_wdata);
            end
            if (remain == 0) begin
              bus.mem_ack = 1'b1;
              if (h_we) begin
                mem_dev[h_addr[3:0]] = h_wdata;
                bus.mem_rdata = $urandom;
              end else begin
                bus.mem_rdata = mem_dev[h_addr[3:0]];
              end
              active = 1'b0;
            end else begin
              bus.mem_ack = 1'b0;
              remain--;
            end
          end else begin
            active        = 1'b0;
            bus.mem_ack   = ($urandom_range(0, 3) == 0);
            bus.mem_rdata = $urandom;
          end
        end
        bus.mem_ack = 1'b0;
      end
      begin : monitor
        wb_t e;
        while (run) begin
          @(negedge clk);
          if (bus.rf_we || bus.sp_we) begin
            checks++;
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL rand wb: unexpected rf_we=%b sp_we=%b, required no write", bus.rf_we, bus.sp_we);
            end else begin
              e = exp_q.pop_front();
              if (bus.rf_we !== e.we || bus.sp_we !== e.sp_we ||
                  (e.we && {bus.rf_waddr, bus.rf_wdata} !== {e.waddr, e.wdata}) ||
                  (e.sp_we && bus.sp_wdata !== e.sp)) begin
                errors++;
                $display("FAIL rand wb: got we=%b a=%0d d=%h sp_we=%b sp=%h expected we=%b a=%0d d=%h sp_we=%b sp=%h",
                         bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.sp_we, bus.sp_wdata,
                         e.we, e.waddr, e.wdata, e.sp_we, e.sp);
              end
            end
          end
        end
      end
    join
    chk32("rand wb drained", 32'(exp_q.size()), 32'd0);
    chk32("rand mem drained", 32'(mexp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
